// File: rtl/state_sequencer.sv
// Display/animation state sequencer feeding variable_clock (45 Hz domain).
// Latency: state updates one clock after a button rising edge or dwell expiry.
// No backpressure: button edges act once in the cycle they are detected.
module state_sequencer #(
   parameter int unsigned DWELL_TICKS = 90,
   parameter int unsigned LAST_STATE  = 15,
   parameter logic [15:0] SLOW_MASK   = 16'h96D8
) (
   input  logic       fourtyfiveHz_clock,
   input  logic       reset,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_pause,
   output logic [4:0] state,
   output logic       state_changed,
   output logic       paused,
   output logic [8:0] dwell_count
);

   localparam logic [4:0] LAST     = 5'(LAST_STATE);
   localparam logic [8:0] LIM_NORM = 9'(DWELL_TICKS - 1);
   localparam logic [8:0] LIM_SLOW = 9'(2 * DWELL_TICKS - 1);

   logic [4:0] state_q, state_d;
   logic [8:0] dwell_q, dwell_d;
   logic       paused_q, paused_d;
   logic       changed_q, changed_d;
   logic       next_hist_q, prev_hist_q, pause_hist_q;

   logic       rise_next, rise_prev, rise_pause;
   logic       step_next, step_prev;
   logic       slow;
   logic [8:0] lim;
   logic [4:0] fwd_state, back_state;

   // Edge detection, step decode and next-state selection in priority order.
   always_comb begin
      rise_next  = btn_next  & ~next_hist_q;
      rise_prev  = btn_prev  & ~prev_hist_q;
      rise_pause = btn_pause & ~pause_hist_q;

      // Simultaneous next+prev cancel each other; auto-advance still applies.
      step_next = rise_next & ~rise_prev;
      step_prev = rise_prev & ~rise_next;

      // States above 15 are never slow.
      slow = (state_q <= 5'd15) && SLOW_MASK[state_q[3:0]];
      lim  = slow ? LIM_SLOW : LIM_NORM;

      // Out-of-range (corrupted) states recover to 0 on any step.
      fwd_state  = (state_q >= LAST) ? 5'd0 : state_q + 5'd1;
      if (state_q > LAST)
         back_state = 5'd0;
      else if (state_q == 5'd0)
         back_state = LAST;
      else
         back_state = state_q - 5'd1;

      state_d   = state_q;
      dwell_d   = dwell_q;
      changed_d = 1'b0;
      paused_d  = paused_q ^ rise_pause;

      if (step_next) begin
         state_d   = fwd_state;
         dwell_d   = 9'd0;
         changed_d = 1'b1;
      end else if (step_prev) begin
         state_d   = back_state;
         dwell_d   = 9'd0;
         changed_d = 1'b1;
      end else if (!paused_q && (dwell_q == lim)) begin
         state_d   = fwd_state;
         dwell_d   = 9'd0;
         changed_d = 1'b1;
      end else if (!paused_q) begin
         dwell_d   = dwell_q + 9'd1;
      end
   end

   // State registers; button history resets high so a held button cannot fire.
   always_ff @(posedge fourtyfiveHz_clock or posedge reset) begin
      if (reset) begin
         state_q      <= 5'd0;
         dwell_q      <= 9'd0;
         paused_q     <= 1'b0;
         changed_q    <= 1'b0;
         next_hist_q  <= 1'b1;
         prev_hist_q  <= 1'b1;
         pause_hist_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         dwell_q      <= dwell_d;
         paused_q     <= paused_d;
         changed_q    <= changed_d;
         next_hist_q  <= btn_next;
         prev_hist_q  <= btn_prev;
         pause_hist_q <= btn_pause;
      end
   end

   assign state         = state_q;
   assign state_changed = changed_q;
   assign paused        = paused_q;
   assign dwell_count   = dwell_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: directed scenarios then randomized button activity,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_state_sequencer;

   localparam int DW = 4;
   localparam int LS = 15;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_next, btn_prev, btn_pause;
   logic [4:0] state;
   logic       state_changed;
   logic       paused;
   logic [8:0] dwell_count;

   int checks = 0;
   int errors = 0;

   // Reference model: plain integers
   int m_s, m_c, m_p, m_chg;
   bit m_hn, m_hp, m_hpa;
   int slow_states[8] = '{3, 4, 6, 7, 9, 10, 12, 15};

   state_sequencer #(.DWELL_TICKS(DW), .LAST_STATE(LS), .SLOW_MASK(16'h96D8)) dut (
      .fourtyfiveHz_clock(clk),
      .reset(reset),
      .btn_next(btn_next),
      .btn_prev(btn_prev),
      .btn_pause(btn_pause),
      .state(state),
      .state_changed(state_changed),
      .paused(paused),
      .dwell_count(dwell_count)
   );

   always #5 clk = ~clk;

   function automatic int m_lim(input int s);
      int k;
      k = 1;
      foreach (slow_states[i]) if (slow_states[i] == s) k = 2;
      return DW * k - 1;
   endfunction

   task automatic m_reset();
      m_s = 0; m_c = 0; m_p = 0; m_chg = 0;
      m_hn = 1'b1; m_hp = 1'b1; m_hpa = 1'b1;
   endtask

   task automatic model_edge(input bit n, input bit p, input bit pa);
      bit rn, rp, rpa;
      rn  = n  && !m_hn;
      rp  = p  && !m_hp;
      rpa = pa && !m_hpa;
      m_chg = 0;
      if (rn && !rp) begin
         m_s = (m_s + 1) % (LS + 1); m_c = 0; m_chg = 1;
      end else if (rp && !rn) begin
         m_s = (m_s + LS) % (LS + 1); m_c = 0; m_chg = 1;
      end else if (m_p == 0) begin
         if (m_c == m_lim(m_s)) begin
            m_s = (m_s + 1) % (LS + 1); m_c = 0; m_chg = 1;
         end else begin
            m_c++;
         end
      end
      if (rpa) m_p = 1 - m_p;
      m_hn = n; m_hp = p; m_hpa = pa;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".state"},   32'(state),         32'(m_s));
      chk({tag, ".changed"}, 32'(state_changed), 32'(m_chg));
      chk({tag, ".paused"},  32'(paused),        32'(m_p));
      chk({tag, ".dwell"},   32'(dwell_count),   32'(m_c));
   endtask

   // Drive levels, take one clock edge, advance model, check #1 after the edge.
   task automatic tick(input bit n, input bit p, input bit pa);
      btn_next = n; btn_prev = p; btn_pause = pa;
      @(posedge clk);
      model_edge(n, p, pa);
      #1;
      chk_model("tick");
   endtask

   initial begin
      bit rn, rp, rpa;
      reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; btn_pause = 1'b0;
      m_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("rst.state", 32'(state), 0);
      chk("rst.changed", 32'(state_changed), 0);
      chk("rst.paused", 32'(paused), 0);
      chk("rst.dwell", 32'(dwell_count), 0);
      reset = 1'b0;

      // Auto-advance timing with DWELL_TICKS=4 (state 3 slow)
      for (int t = 1; t <= 20; t++) begin
         tick(0, 0, 0);
         if (t == 4)  chk("auto.s1", 32'(state), 1);
         if (t == 8)  chk("auto.s2", 32'(state), 2);
         if (t == 12) chk("auto.s3", 32'(state), 3);
         if (t == 19) chk("auto.s3hold", 32'(state), 3);
         if (t == 20) begin
            chk("auto.s4", 32'(state), 4);
            chk("auto.s4pulse", 32'(state_changed), 1);
         end
      end

      // Wrap from slow state 15
      for (int k = 0; k < 200 && m_s != 15; k++) tick(0, 0, 0);
      chk("wrap.reach15", 32'(state), 15);
      repeat (7) tick(0, 0, 0);
      chk("wrap.still15", 32'(state), 15);
      tick(0, 0, 0);
      chk("wrap.to0", 32'(state), 0);
      chk("wrap.pulse", 32'(state_changed), 1);

      // Manual prev wrap, then next back
      tick(0, 1, 0);
      chk("prev.state", 32'(state), 15);
      chk("prev.dwell", 32'(dwell_count), 0);
      tick(0, 0, 0);
      tick(1, 0, 0);
      chk("next.state", 32'(state), 0);
      tick(0, 0, 0);

      // Pause holds the count, manual step still clears it
      tick(0, 0, 1);
      chk("pause.on", 32'(paused), 1);
      chk("pause.dwell", 32'(dwell_count), 2);
      repeat (20) tick(0, 0, 1);
      chk("pause.hold", 32'(dwell_count), 2);
      tick(1, 0, 1);
      chk("pause.next", 32'(state), 1);
      chk("pause.nextclr", 32'(dwell_count), 0);
      tick(0, 0, 1);
      chk("pause.hold0", 32'(dwell_count), 0);
      tick(0, 0, 0);
      tick(0, 0, 1);
      chk("unpause", 32'(paused), 0);
      tick(0, 0, 0);
      chk("unpause.count", 32'(dwell_count), 1);

      // Simultaneous next+prev ignored; manual next at expiry is one step
      tick(1, 1, 0);
      chk("both.state", 32'(state), 1);
      chk("both.nopulse", 32'(state_changed), 0);
      chk("both.count", 32'(dwell_count), 2);
      tick(0, 0, 0);
      chk("atlim.dwell", 32'(dwell_count), 3);
      tick(1, 0, 0);
      chk("atlim.single", 32'(state), 2);
      tick(0, 0, 0);
      chk("atlim.after", 32'(state), 2);

      // Asynchronous reset at state 5 / dwell 3, button held through release
      for (int k = 0; k < 400 && !(m_s == 5 && m_c == 3); k++) tick(0, 0, 0);
      chk("arst.pre_state", 32'(state), 5);
      chk("arst.pre_dwell", 32'(dwell_count), 3);
      #2;
      btn_next = 1'b1;
      reset = 1'b1;
      #1;
      m_reset();
      chk_model("arst.async");
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) tick(1, 0, 0);
      chk("held.nostep", 32'(state), 0);
      tick(0, 0, 0);

      // Randomized button activity with occasional async reset
      begin
         bit n, p, pa;
         n = 0; p = 0; pa = 0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) n  = ~n;
            if ($urandom_range(0, 9) == 0) p  = ~p;
            if ($urandom_range(0, 29) == 0) pa = ~pa;
            if ($urandom_range(0, 599) == 0) begin
               #2;
               btn_next = n; btn_prev = p; btn_pause = pa;
               reset = 1'b1;
               #1;
               m_reset();
               chk_model("rand.arst");
               reset = 1'b0;
            end
            tick(n, p, pa);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
